// File: rtl/order_queue_scorer.sv
// Customer order queue: timed order slots, LFSR-driven spawning, dish matching
// on serving spaces and a saturating score with late penalties.
module order_queue_scorer #(
  parameter int N_SLOTS        = 4,
  parameter int N_SPACES       = 2,
  parameter int DISH_W         = 4,
  parameter int N_DISHES       = 3,
  parameter int TIMER_W        = 5,
  parameter int ORDER_TIME     = 20,
  parameter int FRAMES_PER_SEC = 60,
  parameter int SPAWN_SECS     = 5,
  parameter int POINT_W        = 10,
  parameter int SERVE_POINTS   = 20,
  parameter int EXPIRE_PENALTY = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         vsync,
  input  logic                         timer_go,
  input  logic [N_SPACES*DISH_W-1:0]   check_spaces,
  output logic [N_SPACES-1:0]          clear_spaces,
  output logic [N_SLOTS*DISH_W-1:0]    order_dishes,
  output logic [N_SLOTS-1:0]           order_valid,
  output logic [N_SLOTS*TIMER_W-1:0]   order_times,
  output logic [POINT_W-1:0]           point_total,
  output logic                         expired_pulse
);
  localparam int FR_W = $clog2(FRAMES_PER_SEC + 1);
  localparam int SP_W = $clog2(SPAWN_SECS + 1);
  localparam int SW   = POINT_W + 4;
  localparam logic [FR_W-1:0]      FR_LAST   = FR_W'(FRAMES_PER_SEC - 1);
  localparam logic [SP_W-1:0]      SP_LOAD   = SP_W'(SPAWN_SECS - 1);
  localparam logic signed [SW-1:0] S_SERVE   = SW'(SERVE_POINTS);
  localparam logic signed [SW-1:0] S_PEN     = SW'(EXPIRE_PENALTY);
  localparam logic signed [SW-1:0] S_MAX     = SW'((1 << POINT_W) - 1);
  localparam logic [15:0]          LFSR_SEED = 16'hACE1;

  logic                  vsync_q;
  logic [FR_W-1:0]       frame_q, frame_d;
  logic [SP_W-1:0]       spawn_q, spawn_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [N_SLOTS-1:0]    valid_q, valid_d;
  logic [DISH_W-1:0]     dish_q [N_SLOTS];
  logic [DISH_W-1:0]     dish_d [N_SLOTS];
  logic [TIMER_W-1:0]    time_q [N_SLOTS];
  logic [TIMER_W-1:0]    time_d [N_SLOTS];
  logic [N_SPACES-1:0]   clear_q, clear_d;
  logic [POINT_W-1:0]    point_q, point_d;
  logic                  expired_q, expired_d;
  logic                  frame_tick, sec_tick;
  logic [DISH_W-1:0]     new_dish;

  always_comb begin
    frame_tick = vsync & ~vsync_q;
    sec_tick   = 1'b0;
    frame_d    = frame_q;
    if (timer_go && frame_tick) begin
      if (frame_q == FR_LAST) begin
        frame_d  = '0;
        sec_tick = 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    new_dish = DISH_W'((lfsr_q[7:0] % 8'(N_DISHES)) + 8'd1);
  end

  always_comb begin : slot_update
    logic [N_SLOTS-1:0]    served, expired, spawn_sel;
    logic                  found, any_free;
    logic [DISH_W-1:0]     sd;
    logic signed [SW-1:0]  sum;
    served    = '0;
    expired   = '0;
    spawn_sel = '0;
    found     = 1'b0;
    any_free  = 1'b0;
    sd        = '0;
    valid_d   = valid_q;
    dish_d    = dish_q;
    time_d    = time_q;
    clear_d   = '0;
    spawn_d   = spawn_q;
    sum       = SW'(point_q);

    // A space whose clear pulse is still high holds the dish just consumed.
    if (timer_go) begin
      for (int unsigned s = 0; s < N_SPACES; s++) begin
        sd    = check_spaces[s*DISH_W +: DISH_W];
        found = 1'b0;
        if (sd != '0 && !clear_q[s]) begin
          for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (!found && valid_q[k] && !served[k] && dish_q[k] == sd) begin
              served[k] = 1'b1;
              found     = 1'b1;
            end
          end
        end
        clear_d[s] = found;
      end
    end

    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (sec_tick && valid_q[k]) begin
        if (time_q[k] == TIMER_W'(1)) expired[k] = !served[k];
        else                          time_d[k]  = time_q[k] - 1'b1;
      end
      if (served[k] || expired[k]) begin
        valid_d[k] = 1'b0;
        dish_d[k]  = '0;
        time_d[k]  = '0;
      end
      if (served[k])  sum = sum + S_SERVE;
      if (expired[k]) sum = sum - S_PEN;
      if (!valid_q[k] && !any_free) begin
        any_free     = 1'b1;
        spawn_sel[k] = 1'b1;
      end
    end

    // Free-slot choice uses pre-cycle validity, so slots freed now wait a tick.
    if (sec_tick) begin
      if (spawn_q == '0) begin
        if (any_free) begin
          spawn_d = SP_LOAD;
          for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (spawn_sel[k]) begin
              valid_d[k] = 1'b1;
              dish_d[k]  = new_dish;
              time_d[k]  = TIMER_W'(ORDER_TIME);
            end
          end
        end
      end else begin
        spawn_d = spawn_q - 1'b1;
      end
    end

    if (sum[SW-1])       point_d = '0;
    else if (sum > S_MAX) point_d = '1;
    else                 point_d = sum[POINT_W-1:0];
    expired_d = |expired;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      frame_q   <= '0;
      spawn_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      valid_q   <= '0;
      dish_q    <= '{default: '0};
      time_q    <= '{default: '0};
      clear_q   <= '0;
      point_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      frame_q   <= frame_d;
      spawn_q   <= spawn_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      dish_q    <= dish_d;
      time_q    <= time_d;
      clear_q   <= clear_d;
      point_q   <= point_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    order_dishes = '0;
    order_times  = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      order_dishes[k*DISH_W +: DISH_W]   = dish_q[k];
      order_times[k*TIMER_W +: TIMER_W]  = time_q[k];
    end
  end

  assign order_valid   = valid_q;
  assign clear_spaces  = clear_q;
  assign point_total   = point_q;
  assign expired_pulse = expired_q;

endmodule

// File: tb/tb_order_queue_scorer.sv
// Directed bench for order_queue_scorer: cycle table for spawn/serve basics,
// then sequences for dual spaces, expiry/clamp, serve-vs-expire, saturation, freeze.
module tb_order_queue_scorer;
  logic        clock, reset, vsync, timer_go;
  logic [7:0]  check_spaces;
  logic [1:0]  clear_spaces;
  logic [15:0] order_dishes;
  logic [3:0]  order_valid;
  logic [19:0] order_times;
  logic [9:0]  point_total;
  logic        expired_pulse;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] m;

  order_queue_scorer #(.FRAMES_PER_SEC(2)) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .timer_go(timer_go),
    .check_spaces(check_spaces), .clear_spaces(clear_spaces),
    .order_dishes(order_dishes), .order_valid(order_valid),
    .order_times(order_times), .point_total(point_total),
    .expired_pulse(expired_pulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference LFSR: Fibonacci, taps 16,14,13,11, seed ACE1, free-running.
  always @(posedge clock) begin
    if (reset) m <= 16'hACE1;
    else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  typedef struct {
    logic       rst, go, vs, cap;
    logic [1:0] put;
    logic [3:0] ev;
    logic [1:0] ec;
    logic [9:0] ep;
    logic       ex;
    logic       d0sel;
    logic [4:0] et0;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [3:0] dish_of(input logic [15:0] l);
    logic [7:0] r;
    r = (l[7:0] % 8'd3) + 8'd1;
    return r[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One game second at FRAMES_PER_SEC=2; returns just after the sec_tick edge
  // with the dish a spawn on that edge would receive.
  task automatic tick_second(input logic [7:0] sp, output logic [3:0] pd);
    check_spaces = '0;
    vsync = 1'b0; step();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    vsync = 1'b1; check_spaces = sp; pd = dish_of(m); step();
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; check_spaces = '0; timer_go = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] d0, p, dd, msk;
  logic [3:0] pd [4];
  logic       seen_clr;

  initial begin
    //        rst go vs cap put    ev       ec     ep    ex d0 et0
    tbl[0]  = '{1, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 10'd0,  0, 0, 5'd0};
    tbl[1]  = '{1, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 10'd0,  0, 0, 5'd0};
    tbl[2]  = '{0, 1, 1, 0, 2'b00, 4'b0000, 2'b00, 10'd0,  0, 0, 5'd0};
    tbl[3]  = '{0, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 10'd0,  0, 0, 5'd0};
    tbl[4]  = '{0, 1, 1, 1, 2'b00, 4'b0001, 2'b00, 10'd0,  0, 1, 5'd20};
    tbl[5]  = '{0, 1, 1, 0, 2'b10, 4'b0000, 2'b10, 10'd20, 0, 0, 5'd0};
    tbl[6]  = '{0, 1, 1, 0, 2'b10, 4'b0000, 2'b00, 10'd20, 0, 0, 5'd0};
    tbl[7]  = '{0, 1, 1, 0, 2'b10, 4'b0000, 2'b00, 10'd20, 0, 0, 5'd0};
    tbl[8]  = '{0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 10'd20, 0, 0, 5'd0};
    tbl[9]  = '{0, 0, 1, 0, 2'b00, 4'b0000, 2'b00, 10'd20, 0, 0, 5'd0};
    tbl[10] = '{0, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 10'd20, 0, 0, 5'd0};

    reset = 1'b1; timer_go = 1'b0; vsync = 1'b0; check_spaces = '0; d0 = '0;

    for (int i = 0; i < 11; i++) begin
      reset    = tbl[i].rst;
      timer_go = tbl[i].go;
      vsync    = tbl[i].vs;
      if (tbl[i].cap) d0 = dish_of(m);
      check_spaces = {tbl[i].put[1] ? d0 : 4'h0, tbl[i].put[0] ? d0 : 4'h0};
      step();
      chk($sformatf("row%0d_valid", i), order_valid, tbl[i].ev);
      chk($sformatf("row%0d_clear", i), clear_spaces, tbl[i].ec);
      chk($sformatf("row%0d_points", i), point_total, tbl[i].ep);
      chk($sformatf("row%0d_expired", i), expired_pulse, tbl[i].ex);
      chk($sformatf("row%0d_dish0", i), order_dishes[3:0], tbl[i].d0sel ? d0 : 4'h0);
      chk($sformatf("row%0d_time0", i), order_times[4:0], tbl[i].et0);
    end
    check_spaces = '0;

    // Same dish on both spaces, one matching order: only space 0 is consumed.
    for (int t = 2; t <= 6; t++) tick_second('0, p);
    chk("dual1_spawn_valid", order_valid, 4'b0001);
    chk("dual1_spawn_dish", order_dishes[3:0], p);
    check_spaces = {p, p};
    step();
    check_spaces = '0;
    chk("dual1_clear", clear_spaces, 2'b01);
    chk("dual1_valid", order_valid, 4'b0000);
    chk("dual1_points", point_total, 10'd40);
    step();
    chk("dual1_clear_end", clear_spaces, 2'b00);

    // Fill all four slots; pigeonhole guarantees a repeated dish to serve twice.
    for (int t = 7; t <= 26; t++) begin
      tick_second('0, p);
      if (t % 5 == 1) pd[(t - 11) / 5] = p;
    end
    chk("fill_valid", order_valid, 4'b1111);
    chk("fill_dishes", order_dishes, {pd[3], pd[2], pd[1], pd[0]});
    dd = '0; msk = '0;
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (dd == '0 && pd[a] == pd[b]) begin
          dd  = pd[a];
          msk = (4'b0001 << a) | (4'b0001 << b);
        end
    check_spaces = {dd, dd};
    step();
    check_spaces = '0;
    chk("dual2_clear", clear_spaces, 2'b11);
    chk("dual2_valid", order_valid, 4'b1111 & ~msk);
    chk("dual2_points", point_total, 10'd80);

    // Expiry, penalty, clamp at zero, spawn-counter hold when full.
    do_reset();
    tick_second('0, p);
    check_spaces = {4'h0, p};
    step();
    check_spaces = '0;
    chk("exp_serve_points", point_total, 10'd20);
    for (int t = 2; t <= 25; t++) begin
      tick_second('0, p);
      if (t % 5 == 1) pd[(t - 6) / 5] = p;
    end
    chk("exp_full_valid", order_valid, 4'b1111);
    chk("exp_full_times", order_times, {5'd16, 5'd11, 5'd6, 5'd1});
    chk("exp_full_dishes", order_dishes, {pd[3], pd[2], pd[1], pd[0]});
    tick_second('0, p);
    chk("exp26_valid", order_valid, 4'b1110);
    chk("exp26_pulse", expired_pulse, 1'b1);
    chk("exp26_points", point_total, 10'd10);
    chk("exp26_time0", order_times[4:0], 5'd0);
    step();
    chk("exp26_pulse_end", expired_pulse, 1'b0);
    tick_second('0, p);
    chk("respawn27_valid", order_valid, 4'b1111);
    chk("respawn27_dish", order_dishes[3:0], p);
    chk("respawn27_time", order_times[4:0], 5'd20);
    for (int t = 28; t <= 31; t++) tick_second('0, p);
    chk("exp31_valid", order_valid, 4'b1101);
    chk("exp31_points", point_total, 10'd0);
    chk("exp31_pulse", expired_pulse, 1'b1);
    tick_second('0, p);
    chk("respawn32_valid", order_valid, 4'b1111);
    for (int t = 33; t <= 36; t++) tick_second('0, p);
    chk("exp36_valid", order_valid, 4'b1011);
    chk("exp36_points_clamp", point_total, 10'd0);
    chk("exp36_pulse", expired_pulse, 1'b1);
    tick_second('0, p);
    chk("respawn37_valid", order_valid, 4'b1111);
    chk("respawn37_dish2", order_dishes[11:8], p);

    // Serve lands on the same edge as slot 0's expiry: serve wins.
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      tick_second('0, p);
      if (t % 5 == 1) pd[(t - 1) / 5] = p;
    end
    chk("race_time0", order_times[4:0], 5'd1);
    tick_second({4'h0, pd[0]}, p);
    check_spaces = '0;
    chk("race_valid", order_valid, 4'b1110);
    chk("race_clear", clear_spaces, 2'b01);
    chk("race_points", point_total, 10'd20);
    chk("race_pulse", expired_pulse, 1'b0);
    step();
    chk("race_pulse_after", expired_pulse, 1'b0);

    // Saturation: 51 serves reach 1020, the 52nd clamps at 1023.
    do_reset();
    for (int i = 0; i < 52; i++) begin
      for (int t = 0; t < ((i == 0) ? 1 : 5); t++) tick_second('0, p);
      check_spaces = {4'h0, p};
      step();
      check_spaces = '0;
      if (i == 50) chk("sat_1020", point_total, 10'd1020);
    end
    chk("sat_1023", point_total, 10'd1023);

    // Freeze with a matching dish on the space: nothing may move.
    for (int t = 0; t < 6; t++) tick_second('0, p);
    timer_go = 1'b0;
    check_spaces = {4'h0, order_dishes[3:0]};
    seen_clr = 1'b0;
    for (int n = 0; n < 100; n++) begin
      vsync = 1'b1; step();
      if (clear_spaces != 2'b00) seen_clr = 1'b1;
      vsync = 1'b0; step();
      if (clear_spaces != 2'b00) seen_clr = 1'b1;
    end
    chk("frz_clear_seen", seen_clr, 1'b0);
    chk("frz_valid", order_valid, 4'b0001);
    chk("frz_time0", order_times[4:0], 5'd19);
    chk("frz_points", point_total, 10'd1023);
    check_spaces = '0;
    timer_go = 1'b1;
    tick_second('0, p);
    chk("unfrz_time0", order_times[4:0], 5'd18);

    // Reset in the middle of a game.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", order_valid, 4'b0000);
    chk("midrst_dishes", order_dishes, 16'h0000);
    chk("midrst_times", order_times, 20'h00000);
    chk("midrst_points", point_total, 10'd0);
    chk("midrst_clear", clear_spaces, 2'b00);
    chk("midrst_pulse", expired_pulse, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

endmodule
